pps_tod_counter: RTL and testbench
==================================

PPS_TOD_COUNTER -- requirements
Module: pps_tod_counter

Interface
REQ-001 SHALL have parameter C_CLOCK_FREQUENCY, default 125000000, clk cycles per second (N).
REQ-002 SHALL have parameter C_WINDOW, default 16, PPS acceptance half-window in cycles (W); legal range 1..N/4.
REQ-003 SHALL have parameter C_SEC_WIDTH, default 32, seconds counter width.
REQ-004 clk  in  1  core clock; sole clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 pps_in  in  1  single-cycle 1PPS pulse from PPS receiver.
REQ-007 pps_valid  in  1  PPS receiver status; pps_in ignored while low.
REQ-008 tod_load_sec  in  C_SEC_WIDTH  seconds value to apply at next boundary.
REQ-009 tod_load_valid  in  1 / tod_load_ready  out  1  load handshake.
REQ-010 tod_sec  out  C_SEC_WIDTH  seconds count.
REQ-011 tod_subsec  out  $clog2(N)  cycle index within second, 0..N-1.
REQ-012 tod_pulse  out  1  one-cycle pulse, first cycle of each second (subsec==0 after wrap).
REQ-013 tod_state  out  2  UNSYNC=0, SYNC=1, HOLDOVER=2.
REQ-014 fault_count  out  16  saturating fault counter (see Configuration).

Function
REQ-015 "Accepted pps" = pps_in && pps_valid; all pps rules below apply to accepted pps only.
REQ-016 Free-run: subsec increments each cycle; at subsec==N-1 next subsec=0, sec+1 (wraps at 2^C_SEC_WIDTH), tod_pulse=1 next cycle ("boundary").
REQ-017 UNSYNC: accepted pps at any subsec -> boundary next cycle (subsec 0, sec+1, pulse), state SYNC.
REQ-018 SYNC/HOLDOVER, pps at subsec in [N-1-W, N-1] (early/coincident) -> boundary next cycle; state SYNC.
REQ-019 SYNC/HOLDOVER, pps at subsec in [0, W-1] (late) -> next subsec=0, sec unchanged, no pulse; state SYNC.
REQ-020 SYNC/HOLDOVER, pps outside window -> no realignment, fault event, state UNSYNC.
REQ-021 SYNC: subsec reaches W after a free-run (non-pps) boundary with no accepted pps since -> fault event, state HOLDOVER; counting continues free-run.
REQ-022 HOLDOVER: repeated missed pps SHALL NOT generate further fault events.
REQ-023 tod_load_ready=1 when no load pending; accept on valid&&ready; ready low while pending.
REQ-024 At next boundary after acceptance, sec <- pending value instead of sec+1; ready returns 1 the following cycle.
REQ-025 Load accepted in the same cycle as a boundary applies at the following boundary.
REQ-026 Late-pps realignment (REQ-019) is not a boundary and SHALL NOT consume a pending load.
REQ-027 Latency pps_in -> tod_subsec/tod_pulse update: exactly 1 cycle; all outputs registered.

Reset
REQ-028 rst_n low: tod_sec=0, tod_subsec=0, tod_pulse=0, tod_state=UNSYNC, fault_count=0, no load pending, tod_load_ready=1.
REQ-029 Reset mid-second or with load pending SHALL discard pending load; counting resumes from 0 in UNSYNC on first cycle after deassertion.

Configuration
REQ-030 Macro PPS_TOD_FAULT_CNT_EN defined: fault_count increments by 1 per fault event, saturates at 0xFFFF.
REQ-031 Macro undefined: fault_count port present, constant 0; state behaviour unchanged.

Structure
REQ-032 Shared package pps_pkg SHALL hold the tod_state encoding enum and its 2-bit typedef.
REQ-033 IP-integrator wrapper pps_tod_counter SHALL instantiate single sub-module pps_tod_counter_top holding all logic.

Verification (N=1000, W=4, C_SEC_WIDTH=32)
REQ-034 rst_n low mid-count with load pending -> all outputs 0, state 0, ready 1; post-reset, first boundary yields sec=1 (load discarded).
REQ-035 UNSYNC, pps at subsec 317 -> next cycle subsec 0, sec+1, tod_pulse 1 cycle, state SYNC.
REQ-036 SYNC, pps at subsec 997 -> early boundary, sec+1; later pps at subsec 2 -> subsec 0, sec unchanged, no pulse.
REQ-037 SYNC, pps stopped -> at subsec 4 after free-run boundary state HOLDOVER, fault_count 1; pps at subsec 999 -> SYNC.
REQ-038 SYNC, pps at subsec 500 -> state UNSYNC, fault_count+1, no realignment; next pps realigns and returns SYNC.
REQ-039 Load 0x12345678 at subsec 500 -> ready 0; at boundary sec=0x12345678; ready 1 next cycle; pps_valid=0 pulses ignored throughout.

Source files
------------

// File: rtl/pps_pkg.sv
// Shared definitions for the PPS time-of-day counter: tracking state encoding
// and fault counter width.
package pps_pkg;

   localparam int TOD_STATE_W = 2;
   localparam int FAULT_CNT_W = 16;

   typedef enum logic [TOD_STATE_W-1:0] {
      UNSYNC   = 2'd0,
      SYNC     = 2'd1,
      HOLDOVER = 2'd2
   } tod_state_t;

endpackage

// File: rtl/pps_tod_counter_if.sv
// Seconds-load handshake between a time source (master) and the TOD counter
// (slave). The counter raises ready while it has no load waiting for a boundary.
interface pps_tod_counter_if #(
   parameter int C_SEC_WIDTH = 32
) ();

   logic [C_SEC_WIDTH-1:0] tod_load_sec;
   logic                   tod_load_valid;
   logic                   tod_load_ready;

   modport master (
      output tod_load_sec,
      output tod_load_valid,
      input  tod_load_ready
   );

   modport slave (
      input  tod_load_sec,
      input  tod_load_valid,
      output tod_load_ready
   );

endinterface

// File: rtl/pps_tod_counter_top.sv
// Time-of-day core: free-running second/subsecond counter disciplined by an
// external 1PPS pulse, with UNSYNC/SYNC/HOLDOVER tracking, a deferred seconds
// load and an optional saturating fault counter (PPS_TOD_FAULT_CNT_EN).
module pps_tod_counter_top
   import pps_pkg::*;
#(
   parameter int C_CLOCK_FREQUENCY = 125000000,
   parameter int C_WINDOW          = 16,
   parameter int C_SEC_WIDTH       = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 pps_in,
   input  logic                                 pps_valid,
   pps_tod_counter_if.slave                     load,
   output logic [C_SEC_WIDTH-1:0]               tod_sec,
   output logic [$clog2(C_CLOCK_FREQUENCY)-1:0] tod_subsec,
   output logic                                 tod_pulse,
   output logic [TOD_STATE_W-1:0]               tod_state,
   output logic [FAULT_CNT_W-1:0]               fault_count
);

   localparam int SUB_W = $clog2(C_CLOCK_FREQUENCY);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(C_CLOCK_FREQUENCY - 1);
   localparam logic [SUB_W-1:0] SUB_EARLY = SUB_W'(C_CLOCK_FREQUENCY - 1 - C_WINDOW);
   localparam logic [SUB_W-1:0] SUB_WIN   = SUB_W'(C_WINDOW);
   localparam logic [SUB_W-1:0] SUB_MISS  = SUB_W'(C_WINDOW - 1);

   tod_state_t             state;
   tod_state_t             state_nxt;
   logic                   accepted;
   logic                   boundary;
   logic                   realign;
   logic                   fault;
   logic                   armed;
   logic                   armed_nxt;
   logic                   pending;
   logic                   ready;
   logic                   load_fire;
   logic [C_SEC_WIDTH-1:0] pending_sec;

   assign accepted  = pps_in && pps_valid;
   assign load_fire = load.tod_load_valid && ready;

   assign load.tod_load_ready = ready;
   assign tod_state           = state;

   // Decide what this cycle's pps (or its absence) does to the timeline.
   // "armed" means a free-run boundary happened with no pps since, so the
   // end of the late window without a pps is a missed pulse.
   always_comb begin
      state_nxt = state;
      boundary  = 1'b0;
      realign   = 1'b0;
      fault     = 1'b0;
      armed_nxt = armed;
      if (accepted) begin
         armed_nxt = 1'b0;
         if (state == UNSYNC) begin
            boundary  = 1'b1;
            state_nxt = SYNC;
         end else if (tod_subsec >= SUB_EARLY) begin
            boundary  = 1'b1;
            state_nxt = SYNC;
         end else if (tod_subsec < SUB_WIN) begin
            realign   = 1'b1;
            state_nxt = SYNC;
         end else begin
            fault     = 1'b1;
            state_nxt = UNSYNC;
         end
      end else if (tod_subsec >= SUB_LAST) begin
         boundary  = 1'b1;
         armed_nxt = 1'b1;
      end else if (state == SYNC && armed && tod_subsec == SUB_MISS) begin
         fault     = 1'b1;
         state_nxt = HOLDOVER;
      end
   end

   // Tracking state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= UNSYNC;
      else        state <= state_nxt;
   end

   // Second/subsecond counters; a pending load replaces the seconds increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tod_sec    <= '0;
         tod_subsec <= '0;
         tod_pulse  <= 1'b0;
         armed      <= 1'b0;
      end else begin
         tod_pulse <= boundary;
         armed     <= armed_nxt;
         if (boundary || realign) tod_subsec <= '0;
         else                     tod_subsec <= tod_subsec + SUB_W'(1);
         if (boundary) tod_sec <= pending ? pending_sec : tod_sec + C_SEC_WIDTH'(1);
      end
   end

   // Load handshake: one load may wait for the next boundary; a load taken
   // on a boundary cycle waits for the following one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         ready   <= 1'b1;
      end else begin
         if (load_fire)     pending <= 1'b1;
         else if (boundary) pending <= 1'b0;
         ready <= !(load_fire || (pending && !boundary));
      end
   end

   // Captured seconds value; only meaningful while pending is set.
   always_ff @(posedge clk) begin
      if (load_fire) pending_sec <= load.tod_load_sec;
   end

`ifdef PPS_TOD_FAULT_CNT_EN
   function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
      return (v == {FAULT_CNT_W{1'b1}}) ? v : v + FAULT_CNT_W'(1);
   endfunction

   // Saturating count of fault events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     fault_count <= '0;
      else if (fault) fault_count <= sat_inc(fault_count);
   end
`else
   logic unused_fault;
   assign unused_fault = fault;
   assign fault_count  = '0;
`endif

endmodule

// File: rtl/pps_tod_counter.sv
// Integration wrapper for the PPS time-of-day counter. All logic lives in
// pps_tod_counter_top. Define PPS_TOD_FAULT_CNT_EN to enable fault counting;
// otherwise fault_count reads 0.
module pps_tod_counter
   import pps_pkg::*;
#(
   parameter int C_CLOCK_FREQUENCY = 125000000,
   parameter int C_WINDOW          = 16,
   parameter int C_SEC_WIDTH       = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 pps_in,
   input  logic                                 pps_valid,
   pps_tod_counter_if.slave                     load,
   output logic [C_SEC_WIDTH-1:0]               tod_sec,
   output logic [$clog2(C_CLOCK_FREQUENCY)-1:0] tod_subsec,
   output logic                                 tod_pulse,
   output logic [TOD_STATE_W-1:0]               tod_state,
   output logic [FAULT_CNT_W-1:0]               fault_count
);

   pps_tod_counter_top #(
      .C_CLOCK_FREQUENCY (C_CLOCK_FREQUENCY),
      .C_WINDOW          (C_WINDOW),
      .C_SEC_WIDTH       (C_SEC_WIDTH)
   ) u_top (
      .clk         (clk),
      .rst_n       (rst_n),
      .pps_in      (pps_in),
      .pps_valid   (pps_valid),
      .load        (load),
      .tod_sec     (tod_sec),
      .tod_subsec  (tod_subsec),
      .tod_pulse   (tod_pulse),
      .tod_state   (tod_state),
      .fault_count (fault_count)
   );

endmodule

// File: tb/tb_pps_tod_counter.sv
// Directed bench for pps_tod_counter at N=1000, W=4, 32-bit seconds.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_pps_tod_counter;

   localparam int N  = 1000;
   localparam int W  = 4;
   localparam int SW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pps_in = 1'b0;
   logic          pps_valid = 1'b1;
   logic [SW-1:0] tod_sec;
   logic [9:0]    tod_subsec;
   logic          tod_pulse;
   logic [1:0]    tod_state;
   logic [15:0]   fault_count;

   int num_checks = 0;
   int num_errors = 0;
   int exp_fc     = 0;

   pps_tod_counter_if #(.C_SEC_WIDTH(SW)) load_if ();

   pps_tod_counter #(
      .C_CLOCK_FREQUENCY (N),
      .C_WINDOW          (W),
      .C_SEC_WIDTH       (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pps_in      (pps_in),
      .pps_valid   (pps_valid),
      .load        (load_if),
      .tod_sec     (tod_sec),
      .tod_subsec  (tod_subsec),
      .tod_pulse   (tod_pulse),
      .tod_state   (tod_state),
      .fault_count (fault_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_subsec(input int target);
      int budget;
      budget = 2100;
      while (tod_subsec != 10'(target) && budget > 0) begin
         tick();
         budget--;
      end
      check("reach_subsec", 64'(tod_subsec), 64'(target));
   endtask

   task automatic fire_pps(input logic v);
      pps_in    = 1'b1;
      pps_valid = v;
      tick();
      pps_in    = 1'b0;
      pps_valid = 1'b1;
   endtask

   task automatic do_load(input logic [SW-1:0] value);
      load_if.tod_load_sec   = value;
      load_if.tod_load_valid = 1'b1;
      tick();
      load_if.tod_load_valid = 1'b0;
   endtask

   task automatic fault_event();
`ifdef PPS_TOD_FAULT_CNT_EN
      exp_fc++;
`endif
   endtask

   task automatic check_tod(input string tag, input int sub, input logic [SW-1:0] sec,
                            input logic pulse, input int st);
      check({tag, "_subsec"}, 64'(tod_subsec), 64'(sub));
      check({tag, "_sec"},    64'(tod_sec),    64'(sec));
      check({tag, "_pulse"},  64'(tod_pulse),  64'(pulse));
      check({tag, "_state"},  64'(tod_state),  64'(st));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      load_if.tod_load_sec   = '0;
      load_if.tod_load_valid = 1'b0;

      // Power-on reset
      tick(3);
      check_tod("por", 0, 0, 0, 0);
      check("por_fault", 64'(fault_count), 0);
      check("por_ready", 64'(load_if.tod_load_ready), 1);
      rst_n = 1'b1;
      tick(20);
      check("run_subsec", 64'(tod_subsec), 20);

      // Reset mid-second with a pending load discards the load
      do_load(32'h0000_0055);
      check("pend_ready", 64'(load_if.tod_load_ready), 0);
      #2 rst_n = 1'b0;
      #1;
      check_tod("arst", 0, 0, 0, 0);
      check("arst_ready", 64'(load_if.tod_load_ready), 1);
      tick(2);
      rst_n = 1'b1;
      tick();
      check("resume_subsec", 64'(tod_subsec), 1);
      wait_subsec(999);
      tick();
      check_tod("post_rst_bnd", 0, 1, 1, 0);

      // Invalid pps ignored in UNSYNC
      wait_subsec(100);
      fire_pps(1'b0);
      check_tod("inv_unsync", 101, 1, 0, 0);

      // UNSYNC pps at 317 -> boundary, SYNC
      wait_subsec(317);
      fire_pps(1'b1);
      check_tod("unsync_pps", 0, 2, 1, 1);
      tick();
      check_tod("unsync_pps_next", 1, 2, 0, 1);

      // Early pps at 997 -> boundary; late pps at 2 -> realign only
      wait_subsec(997);
      fire_pps(1'b1);
      check_tod("early_pps", 0, 3, 1, 1);
      wait_subsec(2);
      fire_pps(1'b1);
      check_tod("late_pps", 0, 3, 0, 1);

      // Invalid pps ignored in SYNC
      wait_subsec(300);
      fire_pps(1'b0);
      check_tod("inv_sync", 301, 3, 0, 1);

      // Out-of-window pps -> UNSYNC, fault, no realignment; next pps realigns
      wait_subsec(500);
      fire_pps(1'b1);
      fault_event();
      check_tod("outwin_pps", 501, 3, 0, 0);
      check("outwin_fault", 64'(fault_count), 64'(exp_fc));
      wait_subsec(600);
      fire_pps(1'b1);
      check_tod("resync_pps", 0, 4, 1, 1);

      // Missed pps -> HOLDOVER at subsec W after free-run boundary
      wait_subsec(999);
      tick();
      check_tod("freerun_bnd", 0, 5, 1, 1);
      tick(3);
      check_tod("pre_holdover", 3, 5, 0, 1);
      tick();
      fault_event();
      check_tod("holdover", 4, 5, 0, 2);
      check("holdover_fault", 64'(fault_count), 64'(exp_fc));
      wait_subsec(999);
      tick(5);
      check_tod("holdover_again", 4, 6, 0, 2);
      check("holdover_no_refault", 64'(fault_count), 64'(exp_fc));
      wait_subsec(999);
      fire_pps(1'b1);
      check_tod("holdover_resync", 0, 7, 1, 1);

      // Seconds load applied at next boundary; invalid pps ignored meanwhile
      wait_subsec(500);
      do_load(32'h1234_5678);
      check("load_ready_low", 64'(load_if.tod_load_ready), 0);
      wait_subsec(700);
      fire_pps(1'b0);
      check_tod("load_inv_pps", 701, 7, 0, 1);
      check("load_still_pend", 64'(load_if.tod_load_ready), 0);
      wait_subsec(999);
      tick();
      check_tod("load_bnd", 0, 32'h1234_5678, 1, 1);
      check("load_ready_back", 64'(load_if.tod_load_ready), 1);

      // Late realignment does not consume a pending load
      tick();
      do_load(32'hCAFE_F00D);
      check("load2_ready_low", 64'(load_if.tod_load_ready), 0);
      fire_pps(1'b1);
      check_tod("late_keeps_load", 0, 32'h1234_5678, 0, 1);
      check("late_ready", 64'(load_if.tod_load_ready), 0);
      wait_subsec(999);
      tick();
      check_tod("load2_bnd", 0, 32'hCAFE_F00D, 1, 1);

      // Load accepted on a boundary cycle applies at the following boundary;
      // this second has no pps so HOLDOVER is entered on the way.
      wait_subsec(999);
      fault_event();
      load_if.tod_load_sec   = 32'hFFFF_FFFF;
      load_if.tod_load_valid = 1'b1;
      tick();
      load_if.tod_load_valid = 1'b0;
      check_tod("bnd_load", 0, 32'hCAFE_F00E, 1, 2);
      check("bnd_load_ready", 64'(load_if.tod_load_ready), 0);
      wait_subsec(999);
      tick();
      check_tod("bnd_load_apply", 0, 32'hFFFF_FFFF, 1, 2);
      check("bnd_load_ready_back", 64'(load_if.tod_load_ready), 1);

      // Seconds wrap
      wait_subsec(999);
      tick();
      check_tod("sec_wrap", 0, 0, 1, 2);
      check("final_fault", 64'(fault_count), 64'(exp_fc));

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
